// File: rtl/operand_loader_pkg.sv
// ============================================================================
// Module      : operand_loader_pkg
// Description : Shared widths and state encoding for the 128-bit operand loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package operand_loader_pkg;

  localparam int WORD_W       = 32;
  localparam int WORDS_PER_OP = 4;
  localparam int OP_W         = WORD_W * WORDS_PER_OP;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    PRESENT = 2'd2
  } loader_state_t;

endpackage : operand_loader_pkg

`default_nettype wire

// File: rtl/operand_loader_128.sv
// ============================================================================
// Module      : operand_loader_128
// Description : Assembles two 128-bit operands plus carry-in from a 32-bit word
//               stream and presents them to an adder stage with a valid/ready pair.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_loader_128 #(
  parameter int WORD_W = operand_loader_pkg::WORD_W
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic [WORD_W-1:0]                            Word_i,
  input  logic                                         Word_valid_i,
  output logic                                         Word_ready_o,
  input  logic                                         Cin_i,
  input  logic                                         Clear_i,
  output logic [WORD_W*operand_loader_pkg::WORDS_PER_OP-1:0] A_o,
  output logic [WORD_W*operand_loader_pkg::WORDS_PER_OP-1:0] B_o,
  output logic                                         Cin_o,
  output logic                                         Op_valid_o,
  input  logic                                         Op_ready_i
);

  import operand_loader_pkg::*;

  localparam logic [1:0] c_LAST_WORD = 2'(WORDS_PER_OP - 1);

  loader_state_t r_state;
  logic [1:0]    r_cnt;
  logic          w_xfer;

  // Ready drops while reset is held so no word can be claimed during reset.
  assign Word_ready_o = (r_state != PRESENT) & ~rst_i;
  assign w_xfer       = Word_valid_i & Word_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= LOAD_A;
      r_cnt      <= 2'd0;
      A_o        <= '0;
      B_o        <= '0;
      Cin_o      <= 1'b0;
      Op_valid_o <= 1'b0;
    end else if (Clear_i) begin
      // Operand registers are left alone; only the sequencing is aborted.
      r_state    <= LOAD_A;
      r_cnt      <= 2'd0;
      Op_valid_o <= 1'b0;
    end else begin
      case (r_state)
        LOAD_A: begin
          if (w_xfer) begin
            A_o[int'(r_cnt)*WORD_W +: WORD_W] <= Word_i;
            if (r_cnt == c_LAST_WORD) begin
              r_state <= LOAD_B;
              r_cnt   <= 2'd0;
            end else begin
              r_cnt <= r_cnt + 2'd1;
            end
          end
        end
        LOAD_B: begin
          if (w_xfer) begin
            B_o[int'(r_cnt)*WORD_W +: WORD_W] <= Word_i;
            if (r_cnt == c_LAST_WORD) begin
              Cin_o      <= Cin_i;
              r_state    <= PRESENT;
              r_cnt      <= 2'd0;
              Op_valid_o <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 2'd1;
            end
          end
        end
        PRESENT: begin
          if (Op_ready_i) begin
            r_state    <= LOAD_A;
            r_cnt      <= 2'd0;
            Op_valid_o <= 1'b0;
          end
        end
        default: begin
          r_state    <= LOAD_A;
          r_cnt      <= 2'd0;
          Op_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule : operand_loader_128

`default_nettype wire

// File: doc/operand_loader_128.md
OPERAND_LOADER_128 -- requirements
Module: operand_loader_128

Interface
REQ-001 Parameter: WORD_W, default 32, width of one inbound operand word; fixed so that 4 words form one 128-bit operand.
REQ-002 clk_i  input  1  single clock; every register updates on the rising edge.
REQ-003 rst_i  input  1  asynchronous, active-high reset.
REQ-004 Word_i  input  32  operand word; A words arrive first, then B words, least-significant word first.
REQ-005 Word_valid_i  input  1  Word_i holds a valid word.
REQ-006 Word_ready_o  output  1  block can accept a word this cycle.
REQ-007 Cin_i  input  1  carry-in for the pair, sampled with the 4th B word.
REQ-008 Clear_i  input  1  synchronous abort of the pair being assembled or presented.
REQ-009 A_o  output  128  assembled operand A, driven to the 128-bit adder stage.
REQ-010 B_o  output  128  assembled operand B, driven to the 128-bit adder stage.
REQ-011 Cin_o  output  1  captured carry-in for the adder stage.
REQ-012 Op_valid_o  output  1  A_o, B_o and Cin_o form a complete pair.
REQ-013 Op_ready_i  input  1  consumer accepts the presented pair.

Function
REQ-014 States: LOAD_A, LOAD_B, PRESENT, plus a 2-bit word counter cnt.
REQ-015 Word transfer occurs when Word_valid_i & Word_ready_o are both high; no other cycle changes cnt, A_o or B_o.
REQ-016 Word_ready_o = (state != PRESENT) & ~rst_i, combinational.
REQ-017 In LOAD_A, a transfer writes Word_i to A_o[32*cnt+31 : 32*cnt]; on cnt==3 the block moves to LOAD_B with cnt=0, otherwise cnt increments.
REQ-018 In LOAD_B, a transfer writes Word_i to B_o[32*cnt+31 : 32*cnt]. On cnt==3 the same edge captures Cin_i into Cin_o, moves to PRESENT and sets Op_valid_o; otherwise cnt increments.
REQ-019 Op_valid_o is registered and high exactly while the state is PRESENT.
REQ-020 In PRESENT, A_o, B_o, Cin_o and Op_valid_o stay stable until Op_ready_i is high, and Word_valid_i is ignored.
REQ-021 In PRESENT, Op_ready_i high completes the handshake; the next state is LOAD_A with cnt=0.
REQ-022 Op_valid_o falls in the cycle after the handshake.
REQ-023 Minimum period per pair is 9 cycles: 8 word transfers plus 1 present cycle.
REQ-024 After a handshake, A_o, B_o and Cin_o keep their old values until overwritten word by word; they are meaningful only while Op_valid_o is high.
REQ-025 Clear_i high, in any state, forces LOAD_A, cnt=0 and Op_valid_o=0 on the next edge.
REQ-026 Clear_i has priority over a simultaneous word transfer (the word is discarded) and over a simultaneous Op_ready_i (no handshake occurs).
REQ-027 Clear_i does not modify A_o, B_o or Cin_o.
REQ-028 Op_ready_i is ignored outside PRESENT.

Reset
REQ-029 While rst_i is high, asynchronously: state=LOAD_A, cnt=0, A_o=0, B_o=0, Cin_o=0, Op_valid_o=0, Word_ready_o=0.
REQ-030 Reset mid-operation discards any partial or presented pair; the first word accepted after release is A word 0.

Structure
REQ-031 Package operand_loader_pkg holds WORD_W, WORDS_PER_OP=4, OP_W=128 and the state enum {LOAD_A, LOAD_B, PRESENT}.
REQ-032 The block is a single module with no sub-module; the 128-bit adder stage is instantiated beside it by the integrating top.

Verification
REQ-033 Reset: assert rst_i during LOAD_B at cnt=2 -> all outputs 0 immediately; after release, A word 0x11111111 lands in A_o[31:0].
REQ-034 Ordering: A words 0x1, 0x2, 0x3, 0x4 -> A_o = 0x00000004_00000003_00000002_00000001.
REQ-035 Pair presentation: A = 4×0xFFFFFFFF, B words 0x1, 0, 0, 0, Cin_i=0 -> Op_valid_o high the cycle after the 8th accept; adder stage shows Sum=0, Cout=1.
REQ-036 Backpressure: Op_ready_i low 5 cycles with Word_valid_i high -> Word_ready_o=0, and Op_valid_o, A_o, B_o, Cin_o are unchanged over all 5 cycles.
REQ-037 Clear: Clear_i with Word_valid_i on the 3rd B word -> word dropped, state LOAD_A, cnt=0. Clear_i with Op_ready_i in PRESENT -> no handshake counted, Op_valid_o=0 next cycle.
REQ-038 Throughput: continuous Word_valid_i and Op_ready_i high for 3 pairs -> Op_valid_o pulses 1 cycle wide, every 9 cycles, each pair correct; Word_valid_i gaps lengthen the period only by the gap count.
